i2s_sync_filter_bank: RTL

//  Multi-channel synchroniser for asynchronous I2S-side inputs (SCK/WS/SD, external status pins).

---
 rtl/i2s_sync_filter_bank.sv | 91 +++++++++
 1 files changed

// File: rtl/i2s_sync_filter_bank.sv
// i2s_sync_filter_bank
// Multi-channel synchroniser for asynchronous I2S pad inputs (SCK/WS/SD and
// status pins). Each channel runs through a STAGES-deep flop chain, then an
// optional persistence filter that accepts a new level only after it has been
// seen for FILT consecutive cycles. Registered rise/fall pulses mark every
// change of the filtered level.
module i2s_sync_filter_bank #(
  parameter int               WIDTH   = 4,
  parameter int               STAGES  = 2,
  parameter int               FILT    = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             filt_en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter only ever needs to reach FILT-1; keep at least one bit so the
  // bypass-only configuration still elaborates cleanly.
  localparam int             CW       = (FILT < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'((FILT >= 1) ? FILT - 1 : 0);
  localparam logic           FILT_ON  = (FILT >= 1);

  // Stage 0 is the first flop after the pad; stage STAGES-1 is the settled level.
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0]     r_cnt;

  logic [WIDTH-1:0]             w_s;
  logic                         w_active;
  logic [WIDTH-1:0]             w_dout_next;
  logic [WIDTH-1:0][CW-1:0]     w_cnt_next;

  assign w_s      = r_sync[STAGES-1];
  assign w_active = filt_en & FILT_ON;

  // Synchroniser chain: din enters stage 0 directly, each stage copies the one before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain is a bank of ordinary flops, not a RAM, so every stage
      // takes the reset value; otherwise s would carry X into dout after reset.
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking assignment lets every stage sample the old value of
      // its neighbour, which is what makes this a shift rather than a wire.
      r_sync <= {r_sync[STAGES-2:0], din};
    end
  end

  // Per-channel filter decision: next filtered level and next persistence count.
  always_comb begin
    // NOTE: defaults first so every path through the loop assigns both
    // signals; a missed branch would otherwise infer a latch.
    w_dout_next = dout;
    w_cnt_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_active) begin
        // Bypass: follow the synchronised level, any partial count is dropped.
        w_dout_next[i] = w_s[i];
      end else if (w_s[i] != dout[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          // New level has persisted long enough: accept it and restart.
          w_dout_next[i] = w_s[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
      // s matching dout (including a glitch that returned early) leaves the
      // count at its default of zero.
    end
  end

  // Filtered level, counters and edge pulses all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= RST_VAL;
      r_cnt <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      dout  <= w_dout_next;
      r_cnt <= w_cnt_next;
      rise  <= ~dout & w_dout_next;
      fall  <= dout & ~w_dout_next;
    end
  end

endmodule
